if_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the cpu core. After i_start it generates sequential PCs and issues one-outstanding requests to instruction memory. Returned words are buffered with their PC in a small queue that feeds the ID stage through a valid/ready handshake. A redirect from EX (branch/jump) flushes the queue, squashes any in-flight response and restarts fetch at the new PC.

---
 rtl/if_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer.
// Once started, it issues fetches at sequential word addresses with at most one request in
// flight. Each returned word is stored with its PC in a small circular queue, and the queue
// feeds the ID stage through a valid/ready handshake. A redirect from EX flushes the queue,
// squashes any acked-but-unreturned response and restarts fetch at the new target.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), asynchronous active-low reset
//   i_start                        begin fetching (sampled only while idle)
//   o_imem_req, o_imem_addr        fetch request and word-aligned address
//   i_imem_ack                     memory accepted the request this cycle
//   i_imem_rvalid, i_imem_rdata    returned instruction word
//   o_id_inst, o_id_pc, o_id_valid queue head towards ID
//   i_id_ready                     ID consumes the head when valid & ready
//   i_redirect, i_redirect_pc      EX redirect strobe and target
//   o_busy                         sequencer has left idle
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StFull, StSquash} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q;
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_after;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic redirect, push, pop, outstanding;

  // Redirects are meaningless before fetching starts.
  assign redirect = i_redirect && (state_q != StIdle);
  assign pop      = o_id_valid && i_id_ready && !redirect;
  assign push     = (state_q == StWait) && i_imem_rvalid && !redirect;

  assign count_after = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

  // An acked request whose response has not yet come back must be drained in StSquash.
  assign outstanding = ((state_q == StReq) && i_imem_ack) ||
                       (((state_q == StWait) || (state_q == StSquash)) && !i_imem_rvalid);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle:   if (i_start) state_d = StReq;
      StReq: begin
        if (i_imem_ack) begin
          pc_d    = pc_q + 32'd4;
          state_d = StWait;
        end
      end
      StWait:   if (i_imem_rvalid) state_d = (count_after < DepthC) ? StReq : StFull;
      StFull:   if (pop) state_d = StReq;
      StSquash: if (i_imem_rvalid) state_d = StReq;
      default:  state_d = StIdle;
    endcase
    if (redirect) begin
      pc_d    = {i_redirect_pc[31:2], 2'b00};
      state_d = outstanding ? StSquash : StReq;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if ((state_q == StReq) && i_imem_ack) req_pc_q <= pc_q;
      if (redirect) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
        count_q <= count_after;
      end
    end
  end

  // Storage needs no reset: the head is only exposed while the queue is non-empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[tail_q] <= i_imem_rdata;
      pc_mem[tail_q]   <= req_pc_q;
    end
  end

  assign o_imem_req  = (state_q == StReq);
  assign o_imem_addr = pc_q;
  assign o_id_valid  = (count_q != '0);
  assign o_id_inst   = o_id_valid ? inst_mem[head_q] : 32'h0;
  assign o_id_pc     = o_id_valid ? pc_mem[head_q] : 32'h0;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level model (started flag,
// one-outstanding flag, stale flag, next PC and a queue of {inst, pc}).
module tb_if_fetch_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, ack = 1'b0, rvalid = 1'b0, ready = 1'b0, redirect = 1'b0;
  logic [31:0] rdata = '0, redirect_pc = '0;
  logic        imem_req, id_valid, busy;
  logic [31:0] imem_addr, id_inst, id_pc;

  if_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(ack), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_id_inst(id_inst), .o_id_pc(id_pc), .o_id_valid(id_valid),
    .i_id_ready(ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model
  bit          m_started, m_out, m_stale;
  logic [31:0] m_pc, m_req_pc;
  logic [63:0] m_q[$];

  // Memory driver, knobs and logs
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          ack_pct = 100, dmin = 1, dmax = 1, ready_pct = 100;
  bit          nx_start, nx_redirect, nx_rst_n = 1'b1;
  logic [31:0] nx_rpc;
  logic [63:0] pops[$];
  logic [31:0] acks[$];
  int          cyc = 0, first_valid = -1;

  // Word i of memory encodes "addi x(11+i), x0, i+1"-like patterns: 0x00100593, 0x00200613...
  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] i;
    i = a >> 2;
    return ((i + 32'd1) << 20) | (32'h593 + (i << 7));
  endfunction

  function automatic bit m_req();
    return m_started && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_started = 0; m_out = 0; m_stale = 0; m_pc = 32'h0; m_req_pc = 32'h0;
    m_q.delete();
  endtask

  task automatic cycle();
    logic [31:0] old_pc;
    bit rq, pp;
    @(negedge clk);
    chk("busy", {31'b0, busy}, {31'b0, m_started});
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("id_inst", id_inst, m_q[0][63:32]);
      chk("id_pc", id_pc, m_q[0][31:0]);
    end
    if (id_valid && first_valid < 0) first_valid = cyc;
    rst_n       = nx_rst_n;
    start       = nx_start;
    redirect    = nx_redirect;
    redirect_pc = nx_rpc;
    ack         = m_req() && ($urandom_range(99) < ack_pct);
    rvalid      = mem_pend && (mem_cnt == 0);
    rdata       = rvalid ? word(mem_addr) : $urandom;
    ready       = ($urandom_range(99) < ready_pct);
    @(posedge clk);
    old_pc = m_pc;
    rq     = m_req();
    if (!rst_n) model_reset();
    else if (!m_started) begin
      if (start) m_started = 1;
    end else begin
      pp = (m_q.size() > 0) && ready && !redirect;
      if (rq && ack) acks.push_back(old_pc);
      if (redirect) begin
        m_q.delete();
        if (rq && ack) begin
          m_out = 1; m_stale = 1;
        end else if (m_out) begin
          if (rvalid) begin m_out = 0; m_stale = 0; end
          else m_stale = 1;
        end
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pp) begin
          pops.push_back(m_q[0]);
          void'(m_q.pop_front());
        end
        if (m_out && rvalid) begin
          if (!m_stale) m_q.push_back({rdata, m_req_pc});
          m_out = 0; m_stale = 0;
        end
        if (rq && ack) begin
          m_out = 1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
        end
      end
    end
    if (rvalid) mem_pend = 0;
    if (ack) begin
      mem_pend = 1; mem_addr = old_pc; mem_cnt = $urandom_range(dmax, dmin) - 1;
    end else if (mem_pend && mem_cnt > 0) mem_cnt--;
    cyc++;
  endtask

  task automatic restart();
    nx_rst_n = 0; cycle();
    nx_rst_n = 1; cycle();
    first_valid = -1;
    nx_start = 1; cycle();
    nx_start = 0;
    pops.delete(); acks.delete();
  endtask

  task automatic run_until_pops(input int n);
    for (int k = 0; k < 60 && pops.size() < n; k++) cycle();
    chk("pops_reached", {31'b0, pops.size() >= n}, 32'd1);
  endtask

  task automatic run_until_acks(input int n);
    for (int k = 0; k < 60 && acks.size() < n; k++) cycle();
    chk("acks_reached", {31'b0, acks.size() >= n}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, np, na;
    bit found;
    model_reset();
    #1 rst_n = 1'b0;
    nx_rst_n = 0;
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    cycle();

    // Basic in-order fetch and start-to-valid latency
    nx_rst_n = 1; cycle();
    nx_start = 1; c0 = cyc; cycle();
    nx_start = 0;
    run_until_pops(3);
    chk("t1_lat", first_valid - c0, 32'd3);
    chk("t1_i0", pops[0][63:32], 32'h00100593);
    chk("t1_p0", pops[0][31:0], 32'h0);
    chk("t1_i1", pops[1][63:32], 32'h00200613);
    chk("t1_p1", pops[1][31:0], 32'h4);
    chk("t1_i2", pops[2][63:32], 32'h00300693);
    chk("t1_p2", pops[2][31:0], 32'h8);

    // Queue full with ID stalled, then drain
    ready_pct = 0;
    restart();
    repeat (20) cycle();
    #2;
    chk("t2_req", {31'b0, imem_req}, 32'd0);
    chk("t2_addr", imem_addr, 32'h10);
    chk("t2_valid", {31'b0, id_valid}, 32'd1);
    chk("t2_head", id_pc, 32'h0);
    ready_pct = 100;
    run_until_pops(4);
    for (int k = 0; k < 4; k++) chk("t2_order", pops[k][31:0], 32'(k * 4));
    run_until_acks(5);
    chk("t2_resume", acks[4], 32'h10);

    // Redirect while waiting on 0x8, response not yet back
    dmin = 2; dmax = 2;
    restart();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_out && m_req_pc == 32'h8 && !(mem_pend && mem_cnt == 0)) found = 1;
      else cycle();
    end
    chk("t3_reach", {31'b0, found}, 32'd1);
    nx_redirect = 1; nx_rpc = 32'h100; cycle();
    nx_redirect = 0;
    #2 chk("t3_flush", {31'b0, id_valid}, 32'd0);
    np = pops.size(); na = acks.size();
    run_until_pops(np + 1);
    chk("t3_ack", acks[na], 32'h100);
    chk("t3_pc", pops[np][31:0], 32'h100);
    chk("t3_inst", pops[np][63:32], 32'h04102593);

    // Redirect coincident with rvalid: no squash, low bits of target cleared
    dmin = 1; dmax = 1;
    restart();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_out && m_req_pc == 32'h8 && mem_pend && mem_cnt == 0) found = 1;
      else cycle();
    end
    chk("t4_reach", {31'b0, found}, 32'd1);
    nx_redirect = 1; nx_rpc = 32'h203; cycle();
    nx_redirect = 0;
    #2;
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_valid", {31'b0, id_valid}, 32'd0);

    // Redirect coincident with ack: squash the acked request
    restart();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_req() && m_pc == 32'h8) found = 1;
      else cycle();
    end
    chk("t5_reach", {31'b0, found}, 32'd1);
    nx_redirect = 1; nx_rpc = 32'h40; cycle();
    nx_redirect = 0;
    #2 chk("t5_squash_req", {31'b0, imem_req}, 32'd0);
    np = pops.size(); na = acks.size();
    run_until_pops(np + 1);
    chk("t5_ack", acks[na], 32'h40);
    chk("t5_pc", pops[np][31:0], 32'h40);

    // Asynchronous reset while a response is pending
    dmin = 2; dmax = 2;
    restart();
    for (int k = 0; k < 20 && !m_out; k++) cycle();
    nx_rst_n = 0; cycle();
    #2;
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_valid", {31'b0, id_valid}, 32'd0);
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    cycle();
    nx_rst_n = 1; cycle(); cycle(); cycle();
    nx_start = 1; cycle();
    nx_start = 0;
    acks.delete(); pops.delete();
    run_until_acks(1);
    chk("t6_addr", acks[0], 32'h0);

    // Randomized traffic
    dmin = 1; dmax = 3;
    restart();
    for (int blk = 0; blk < 20; blk++) begin
      ack_pct   = $urandom_range(100, 20);
      ready_pct = $urandom_range(100, 10);
      for (int k = 0; k < 200; k++) begin
        nx_redirect = ($urandom_range(19) == 0);
        nx_rpc      = $urandom;
        nx_rst_n    = ($urandom_range(499) != 0);
        nx_start    = ($urandom_range(3) == 0);
        cycle();
      end
    end
    nx_redirect = 0; nx_rst_n = 1; nx_start = 0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
